// File: rtl/pmem_burst_adaptor.sv
// Converts 128-bit cache line requests into 4-beat x 32-bit memory bursts.
// Optional PMEM_ADAPTOR_RESP_BYPASS_EN: pmem_resp on the last beat, no RESP state.
module pmem_burst_adaptor (
    input  logic         clk,
    input  logic         rst,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         mem_burst_read,
    output logic         mem_burst_write,
    output logic [15:0]  mem_burst_address,
    output logic [31:0]  mem_burst_wdata,
    input  logic [31:0]  mem_burst_rdata,
    input  logic         mem_burst_rvalid,
    input  logic         mem_burst_wready
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        READ_BURST  = 2'd1,
        WRITE_BURST = 2'd2,
        RESP        = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [1:0]    cnt_reg, cnt_next;
    logic [15:0]   addr_reg;
    logic [127:0]  wdata_reg;

    logic accept;
    logic accept_wr;
    logic rd_beat;
    logic wr_beat;
    logic last_beat;
    logic last_beat_rd;

    assign accept       = (state_reg == IDLE) && (pmem_write || pmem_read);
    assign accept_wr    = (state_reg == IDLE) && pmem_write;
    // Handshakes only count inside the matching burst state.
    assign rd_beat      = (state_reg == READ_BURST) && mem_burst_rvalid;
    assign wr_beat      = (state_reg == WRITE_BURST) && mem_burst_wready;
    assign last_beat    = (rd_beat || wr_beat) && (cnt_reg == 2'd3);
    assign last_beat_rd = rd_beat && (cnt_reg == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg <= pmem_address & 16'hFFF0;
            end
            if (accept_wr) begin
                wdata_reg <= pmem_wdata;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = 2'd0;
                if (pmem_write) begin
                    state_next = WRITE_BURST;
                end else if (pmem_read) begin
                    state_next = READ_BURST;
                end
            end
            READ_BURST, WRITE_BURST: begin
                if (rd_beat || wr_beat) begin
                    cnt_next = cnt_reg + 2'd1;
                    if (last_beat) begin
`ifdef PMEM_ADAPTOR_RESP_BYPASS_EN
                        state_next = IDLE;
`else
                        state_next = RESP;
`endif
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_burst_read    = (state_reg == READ_BURST);
    assign mem_burst_write   = (state_reg == WRITE_BURST);
    assign mem_burst_address = addr_reg;
    assign mem_burst_wdata   = wdata_reg[{cnt_reg, 5'b00000} +: 32];

`ifdef PMEM_ADAPTOR_RESP_BYPASS_EN
    assign pmem_resp = last_beat;
`else
    assign pmem_resp = (state_reg == RESP);
`endif

    // One register per line word; only reads write them, so the line survives writebacks.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_line
            localparam logic [1:0] WORD_IDX = 2'(gi);
            logic [31:0] word_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    word_reg <= '0;
                end else if (rd_beat && (cnt_reg == WORD_IDX)) begin
                    word_reg <= mem_burst_rdata;
                end
            end

`ifdef PMEM_ADAPTOR_RESP_BYPASS_EN
            if (gi == 3) begin : g_bypass
                assign pmem_rdata[32*gi +: 32] = last_beat_rd ? mem_burst_rdata : word_reg;
            end else begin : g_plain
                assign pmem_rdata[32*gi +: 32] = word_reg;
            end
`else
            assign pmem_rdata[32*gi +: 32] = word_reg;
`endif
        end
    endgenerate

`ifndef PMEM_ADAPTOR_RESP_BYPASS_EN
    logic unused_last_beat_rd;
    assign unused_last_beat_rd = last_beat_rd;
`endif

endmodule

// File: tb/tb_pmem_burst_adaptor.sv
// Scoreboard bench for pmem_burst_adaptor: stimulus pushes expectations, a negedge monitor checks them.
module tb_pmem_burst_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         mem_burst_read;
    logic         mem_burst_write;
    logic [15:0]  mem_burst_address;
    logic [31:0]  mem_burst_wdata;
    logic [31:0]  mem_burst_rdata;
    logic         mem_burst_rvalid;
    logic         mem_burst_wready;

    pmem_burst_adaptor dut (
        .clk               (clk),
        .rst               (rst),
        .pmem_read         (pmem_read),
        .pmem_write        (pmem_write),
        .pmem_address      (pmem_address),
        .pmem_wdata        (pmem_wdata),
        .pmem_rdata        (pmem_rdata),
        .pmem_resp         (pmem_resp),
        .mem_burst_read    (mem_burst_read),
        .mem_burst_write   (mem_burst_write),
        .mem_burst_address (mem_burst_address),
        .mem_burst_wdata   (mem_burst_wdata),
        .mem_burst_rdata   (mem_burst_rdata),
        .mem_burst_rvalid  (mem_burst_rvalid),
        .mem_burst_wready  (mem_burst_wready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [127:0] resp_q[$];
    logic [31:0]  wbeat_q[$];
    logic [15:0]  addr_q[$];
    logic [127:0] last_line;

    int cyc_n         = 0;
    int last_resp_cyc = 0;
    int start_gap     = 0;
    int beat_n        = 0;
    int resp_n        = 0;
    bit resp_due      = 1'b0;
    bit burst_prev    = 1'b0;
    bit burst_now;
    logic [127:0] exp_line;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: compares every DUT response / beat / burst start with the queued expectations.
    always @(negedge clk) begin
        cyc_n++;
        if (rst) begin
            beat_n     = 0;
            resp_due   = 1'b0;
            burst_prev = 1'b0;
        end else begin
            if (resp_due) begin
                check("resp_latency", {127'd0, pmem_resp}, 128'd1);
                resp_due = 1'b0;
            end
            if (pmem_resp) begin
                last_resp_cyc = cyc_n;
                if (resp_q.size() > 0) begin
                    exp_line = resp_q.pop_front();
                    resp_n++;
                    check("pmem_rdata", pmem_rdata, exp_line);
                    $display("resp %0d at cycle %0d: rdata=%h", resp_n, cyc_n, pmem_rdata);
                end else begin
                    check("spurious_resp", {127'd0, pmem_resp}, 128'd0);
                end
            end
            burst_now = mem_burst_read | mem_burst_write;
            if (burst_now && !burst_prev) begin
                start_gap = cyc_n - last_resp_cyc;
                if (addr_q.size() > 0) begin
                    check("burst_address", {112'd0, mem_burst_address}, {112'd0, addr_q.pop_front()});
                end else begin
                    check("spurious_burst", {127'd0, burst_now}, 128'd0);
                end
            end
            burst_prev = burst_now;
            if (mem_burst_write) begin
                if (wbeat_q.size() > 0) begin
                    check("burst_wdata", {96'd0, mem_burst_wdata}, {96'd0, wbeat_q[0]});
                    if (mem_burst_wready) void'(wbeat_q.pop_front());
                end else begin
                    check("spurious_write", {127'd0, mem_burst_write}, 128'd0);
                end
            end
            if ((mem_burst_read && mem_burst_rvalid) || (mem_burst_write && mem_burst_wready)) begin
                beat_n++;
                if (beat_n == 4) begin
                    beat_n = 0;
`ifdef PMEM_ADAPTOR_RESP_BYPASS_EN
                    check("resp_latency", {127'd0, pmem_resp}, 128'd1);
`else
                    resp_due = 1'b1;
`endif
                end
            end
        end
    end

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_write(input logic [15:0] addr, input logic [127:0] wd);
        addr_q.push_back(addr & 16'hFFF0);
        for (int k = 0; k < 4; k++) wbeat_q.push_back(wd[32*k +: 32]);
        resp_q.push_back(last_line);
    endtask

    task automatic push_read(input logic [15:0] addr, input logic [31:0] base);
        addr_q.push_back(addr & 16'hFFF0);
        last_line = {base + 32'd3, base + 32'd2, base + 32'd1, base};
        resp_q.push_back(last_line);
    endtask

    // Drives one burst's handshakes (pat bit per cycle) and returns once pmem_resp has been seen.
    task automatic run_burst(input bit is_wr, input logic [15:0] pat, input logic [31:0] rbase,
                             input bit drop_early);
        int guard = 0;
        int beats = 0;
        int cyc   = 0;
        bit hs;
        bit got_resp = 1'b0;
        while (!(is_wr ? mem_burst_write : mem_burst_read) && guard < 20) begin
            wait_cycle();
            guard++;
        end
        check(is_wr ? "write_burst_start" : "read_burst_start",
              {127'd0, (is_wr ? mem_burst_write : mem_burst_read)}, 128'd1);
        if (drop_early) begin
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
        end
        while (beats < 4 && cyc < 40) begin
            hs = (cyc < 16) ? pat[cyc] : 1'b1;
            if (is_wr) begin
                mem_burst_wready = hs;
            end else begin
                mem_burst_rvalid = hs;
                mem_burst_rdata  = hs ? rbase + 32'(beats) : 32'hDEADBEEF;
            end
            @(negedge clk);
            if (pmem_resp) got_resp = 1'b1;
            if (hs) beats++;
            wait_cycle();
            cyc++;
        end
        mem_burst_rvalid = 1'b0;
        mem_burst_wready = 1'b0;
        mem_burst_rdata  = 32'h0BADF00D;
        guard = 0;
        while (!got_resp && guard < 10) begin
            @(negedge clk);
            got_resp = pmem_resp;
            guard++;
        end
        check("resp_seen", {127'd0, got_resp}, 128'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pmem_resp"}, {127'd0, pmem_resp}, 128'd0);
        check({tag, "_burst_read"}, {127'd0, mem_burst_read}, 128'd0);
        check({tag, "_burst_write"}, {127'd0, mem_burst_write}, 128'd0);
        check({tag, "_pmem_rdata"}, pmem_rdata, 128'd0);
        check({tag, "_burst_address"}, {112'd0, mem_burst_address}, 128'd0);
        check({tag, "_burst_wdata"}, {96'd0, mem_burst_wdata}, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_address     = '0;
        pmem_wdata       = '0;
        mem_burst_rdata  = '0;
        mem_burst_rvalid = 1'b0;
        mem_burst_wready = 1'b0;
        last_line        = '0;
        wait_cycle();
        wait_cycle();
        check_all_zero("reset");
        rst = 1'b0;
        wait_cycle();

        // Read 0x1234, four back-to-back beats 0xA0..0xA3
        push_read(16'h1234, 32'hA0);
        pmem_address = 16'h1234;
        pmem_read    = 1'b1;
        run_burst(1'b0, 16'hFFFF, 32'hA0, 1'b0);
        pmem_read = 1'b0;
        wait_cycle();

        // Write with wready high 2 cycles, low 3, then high; line buffer must stay untouched
        push_write(16'h5678, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        pmem_address = 16'h5678;
        pmem_wdata   = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        pmem_write   = 1'b1;
        run_burst(1'b1, 16'hFFE3, 32'h0, 1'b0);
        pmem_write = 1'b0;
        wait_cycle();

        // Write and read together: writeback first, fill accepted right after pmem_resp
        push_write(16'h9ABC, 128'h44444444_33333333_22222222_11111111);
        push_read(16'h9ABC, 32'hC0);
        pmem_address = 16'h9ABC;
        pmem_wdata   = 128'h44444444_33333333_22222222_11111111;
        pmem_write   = 1'b1;
        pmem_read    = 1'b1;
        run_burst(1'b1, 16'hFFFF, 32'h0, 1'b0);
        pmem_write = 1'b0;
        run_burst(1'b0, 16'h5555, 32'hC0, 1'b0);
        pmem_read = 1'b0;
        check("wb_then_fill_gap", 128'(start_gap), 128'd2);
        wait_cycle();

        // Reset after the third read beat
        addr_q.push_back(16'h2000);
        pmem_address = 16'h2000;
        pmem_read    = 1'b1;
        wait_cycle();
        for (int k = 0; k < 3; k++) begin
            mem_burst_rvalid = 1'b1;
            mem_burst_rdata  = 32'h11 * 32'(k + 1);
            wait_cycle();
        end
        mem_burst_rvalid = 1'b0;
        pmem_read        = 1'b0;
        rst              = 1'b1;
        wait_cycle();
        check_all_zero("midburst_reset");
        rst       = 1'b0;
        last_line = '0;
        wait_cycle();

        // Stray handshakes in IDLE change nothing
        for (int k = 0; k < 3; k++) begin
            mem_burst_rvalid = 1'b1;
            mem_burst_wready = 1'b1;
            mem_burst_rdata  = 32'hBADBAD00 + 32'(k);
            @(negedge clk);
            check("stray_burst_read", {127'd0, mem_burst_read}, 128'd0);
            check("stray_burst_write", {127'd0, mem_burst_write}, 128'd0);
            check("stray_resp", {127'd0, pmem_resp}, 128'd0);
            wait_cycle();
        end
        mem_burst_rvalid = 1'b0;
        mem_burst_wready = 1'b0;
        check("stray_rdata", pmem_rdata, 128'd0);

        // Write after reset sees a cleared line buffer
        push_write(16'h3005, 128'h88888888_77777777_66666666_55555555);
        pmem_address = 16'h3005;
        pmem_wdata   = 128'h88888888_77777777_66666666_55555555;
        pmem_write   = 1'b1;
        run_burst(1'b1, 16'hFFFF, 32'h0, 1'b0);
        pmem_write = 1'b0;
        wait_cycle();

        // Read whose request drops right after the burst starts must still complete
        push_read(16'h4448, 32'hE0);
        pmem_address = 16'h4448;
        pmem_read    = 1'b1;
        run_burst(1'b0, 16'hFFF0, 32'hE0, 1'b1);
        pmem_read = 1'b0;

        repeat (5) wait_cycle();
        check("resp_q_drained", 128'(resp_q.size()), 128'd0);
        check("wbeat_q_drained", 128'(wbeat_q.size()), 128'd0);
        check("addr_q_drained", 128'(addr_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmem_burst_adaptor.md
PMEM_BURST_ADAPTOR -- requirements
Module: pmem_burst_adaptor

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port: pmem_read  input  1  cache line fill request; held high by cache until pmem_resp.
REQ-004 SHALL have port: pmem_write  input  1  cache line writeback request; held high by cache until pmem_resp.
REQ-005 SHALL have port: pmem_address  input  16  line byte address; bits [3:0] ignored and driven 0 downstream.
REQ-006 SHALL have port: pmem_wdata  input  128  writeback line.
REQ-007 SHALL have port: pmem_rdata  output  128  fill line; word k = bits [32k+31:32k].
REQ-008 SHALL have port: pmem_resp  output  1  one-cycle pulse, transaction complete.
REQ-009 SHALL have port: mem_burst_read  output  1  burst read request to memory.
REQ-010 SHALL have port: mem_burst_write  output  1  burst write request to memory.
REQ-011 SHALL have port: mem_burst_address  output  16  latched line address, bits [3:0] = 0.
REQ-012 SHALL have port: mem_burst_wdata  output  32  current write beat.
REQ-013 SHALL have port: mem_burst_rdata  input  32  current read beat.
REQ-014 SHALL have port: mem_burst_rvalid  input  1  read beat valid this cycle.
REQ-015 SHALL have port: mem_burst_wready  input  1  write beat accepted this cycle.

Function
REQ-016 SHALL implement states IDLE, READ_BURST, WRITE_BURST, RESP; 2-bit beat counter; 4 beats of 32 bits per line, beat 0 first.
REQ-017 SHALL sample requests only in IDLE; pmem_write has priority over pmem_read when both are high.
REQ-018 SHALL, on accepting a request, latch the address, and for writes also latch pmem_wdata, then enter WRITE_BURST or READ_BURST next cycle with counter 0.
REQ-019 SHALL hold mem_burst_read high throughout READ_BURST; each mem_burst_rvalid stores mem_burst_rdata into word[counter] and increments the counter.
REQ-020 SHALL hold mem_burst_write high throughout WRITE_BURST with mem_burst_wdata = latched word[counter]; each mem_burst_wready increments the counter.
REQ-021 SHALL, on the 4th beat (counter = 3 with rvalid/wready), leave the burst state; counter wraps to 0.
REQ-022 SHALL, without bypass, enter RESP for exactly one cycle asserting pmem_resp with a registered, complete pmem_rdata, then return to IDLE.
REQ-023 SHALL return to IDLE after the resp cycle and accept a new request in the very next cycle (writeback followed immediately by fill).
REQ-024 SHALL ignore mem_burst_rvalid and mem_burst_wready outside the matching burst state.
REQ-025 SHALL keep pmem_rdata stable from pmem_resp until the next read burst's first beat; write transactions SHALL NOT modify it.
REQ-026 SHALL not abort a burst if the cache request drops mid-burst; the burst completes and pmem_resp still pulses.

Reset
REQ-027 SHALL, while rst is high at posedge clk, enter IDLE, zero the counter, the line buffer, and the latched address/wdata; this applies mid-burst.
REQ-028 SHALL drive pmem_resp, mem_burst_read, and mem_burst_write to 0, and pmem_rdata, mem_burst_address, and mem_burst_wdata to 0, in the cycle after reset.

Configuration
REQ-029 SHALL support macro PMEM_ADAPTOR_RESP_BYPASS_EN.
REQ-030 SHALL, when PMEM_ADAPTOR_RESP_BYPASS_EN is defined, skip RESP: pmem_resp is asserted combinationally in the cycle of the 4th beat, with pmem_rdata word 3 driven from mem_burst_rdata on reads; the state returns to IDLE the next cycle. Latency is saved by 1 cycle.
REQ-031 SHALL, when PMEM_ADAPTOR_RESP_BYPASS_EN is undefined, behave per REQ-022; pmem_resp is purely registered.

Verification
REQ-032 SHALL cover a read to 0x1234 with 4 consecutive rvalid beats 0xA0..0xA3: mem_burst_address=0x1230; pmem_rdata=0x000000A3_000000A2_000000A1_000000A0; pmem_resp pulses 1 cycle after the last beat (same cycle with bypass).
REQ-033 SHALL cover a write with wdata=0xDDDD_CCCC_BBBB_AAAA_... and wready held on 2 cycles then low 3 cycles then high: the beat sequence is word0..word3 in order, and wdata is stable while wready is low.
REQ-034 SHALL cover pmem_write and pmem_read both high in IDLE: the write burst runs first, and the read burst starts in the cycle after pmem_resp.
REQ-035 SHALL cover rst asserted after beat 2 of a read: the next cycle is IDLE with all outputs 0, and a subsequent read completes normally with no stale words.
REQ-036 SHALL cover a stray rvalid/wready in IDLE: no state change and no pmem_resp.
